// File: rtl/sobel_filter_if.sv
// Stream-side signal bundle for sobel_filter: the filter is the slave (sinks pixels, sources results),
// the pixel source / result sink is the master.
interface sobel_filter_if #(
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 19
);
    logic              frame_start;
    logic              in_valid;
    logic [PIX_W-1:0]  in_pixel;
    logic [PIX_W-1:0]  threshold;
    logic              out_valid;
    logic [PIX_W-1:0]  out_pixel;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  frame_start, in_valid, in_pixel, threshold,
        output out_valid, out_pixel, out_addr
    );

    modport master (
        output frame_start, in_valid, in_pixel, threshold,
        input  out_valid, out_pixel, out_addr
    );
endinterface

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge filter over a raster image, one result per accepted pixel once primed.
// Define SOBEL_THRESHOLD_EN to binarise the magnitude against pix_if.threshold.
module sobel_filter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    sobel_filter_if.slave pix_if
);
    // Handshake: no backpressure. A pixel is taken on every rising edge with in_valid=1; out_valid
    // qualifies out_pixel/out_addr for exactly one cycle, registered on the edge that took the pixel.

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PRM_W = $clog2(IMG_W + 2);
    localparam int GW    = PIX_W + 4;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [PRM_W-1:0]  PRM_DONE  = PRM_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [PIX_W-1:0]  PIX_MAX   = {PIX_W{1'b1}};
    localparam logic [GW-1:0]     MAG_MAX   = {4'b0000, {PIX_W{1'b1}}};

    logic [PIX_W-1:0]  lb_top_q [IMG_W];
    logic [PIX_W-1:0]  lb_mid_q [IMG_W];
    logic [PIX_W-1:0]  win_q [3][3];
    logic [PIX_W-1:0]  win_d [3][3];

    logic [COL_W-1:0]  in_col_q, in_col_d, in_col_c;
    logic [ROW_W-1:0]  in_row_q, in_row_d, in_row_c;
    logic [COL_W-1:0]  cen_col_q, cen_col_d, cen_col_c;
    logic [ROW_W-1:0]  cen_row_q, cen_row_d, cen_row_c;
    logic [ADDR_W-1:0] cen_addr_q, cen_addr_d, cen_addr_c;
    logic [PRM_W-1:0]  prime_q, prime_d, prime_c;

    logic              out_valid_q, out_valid_d;
    logic [PIX_W-1:0]  out_pixel_q, out_pixel_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]     abs_x, abs_y, mag;
    logic [PIX_W-1:0]  mag_sat, result;
    logic              border, emit;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'({4'b0000, p});
    endfunction

    // frame_start restarts position and priming in the same cycle it may also accept pixel (0,0).
    assign in_col_c   = pix_if.frame_start ? '0 : in_col_q;
    assign in_row_c   = pix_if.frame_start ? '0 : in_row_q;
    assign cen_col_c  = pix_if.frame_start ? '0 : cen_col_q;
    assign cen_row_c  = pix_if.frame_start ? '0 : cen_row_q;
    assign cen_addr_c = pix_if.frame_start ? '0 : cen_addr_q;
    assign prime_c    = pix_if.frame_start ? '0 : prime_q;

    // Row 0 of the window is the oldest line, column 0 the oldest pixel.
    always_comb begin
        win_d = win_q;
        if (pix_if.in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top_q[in_col_c];
            win_d[1][2] = lb_mid_q[in_col_c];
            win_d[2][2] = pix_if.in_pixel;
        end
    end

    always_comb begin
        gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
        gy = (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]));
        abs_x   = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_y   = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag     = abs_x + abs_y;
        mag_sat = (mag > MAG_MAX) ? PIX_MAX : mag[PIX_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
        result  = (mag_sat >= pix_if.threshold) ? PIX_MAX : '0;
`else
        result  = mag_sat;
`endif
        border  = (cen_row_c == '0) || (cen_row_c == ROW_LAST) ||
                  (cen_col_c == '0) || (cen_col_c == COL_LAST);
    end

`ifndef SOBEL_THRESHOLD_EN
    logic unused_threshold;
    assign unused_threshold = ^pix_if.threshold;
`endif

    always_comb begin
        emit        = pix_if.in_valid && (prime_c == PRM_DONE);
        in_col_d    = in_col_c;
        in_row_d    = in_row_c;
        cen_col_d   = cen_col_c;
        cen_row_d   = cen_row_c;
        cen_addr_d  = cen_addr_c;
        prime_d     = prime_c;
        out_valid_d = emit;
        out_pixel_d = out_pixel_q;
        out_addr_d  = out_addr_q;
        if (pix_if.in_valid) begin
            if (in_col_c == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_c == ROW_LAST) ? '0 : in_row_c + 1'b1;
            end else begin
                in_col_d = in_col_c + 1'b1;
            end
            if (!emit) prime_d = prime_c + 1'b1;
        end
        // The centre trails the input by IMG_W+1 positions, so it gets its own raster counters.
        if (emit) begin
            out_pixel_d = border ? '0 : result;
            out_addr_d  = cen_addr_c;
            cen_addr_d  = (cen_addr_c == ADDR_LAST) ? '0 : cen_addr_c + 1'b1;
            if (cen_col_c == COL_LAST) begin
                cen_col_d = '0;
                cen_row_d = (cen_row_c == ROW_LAST) ? '0 : cen_row_c + 1'b1;
            end else begin
                cen_col_d = cen_col_c + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb_top_q[i] <= '0;
                lb_mid_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            in_col_q    <= '0;
            in_row_q    <= '0;
            cen_col_q   <= '0;
            cen_row_q   <= '0;
            cen_addr_q  <= '0;
            prime_q     <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_addr_q  <= '0;
        end else begin
            win_q <= win_d;
            if (pix_if.in_valid) begin
                lb_top_q[in_col_c] <= lb_mid_q[in_col_c];
                lb_mid_q[in_col_c] <= pix_if.in_pixel;
            end
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            cen_col_q   <= cen_col_d;
            cen_row_q   <= cen_row_d;
            cen_addr_q  <= cen_addr_d;
            prime_q     <= prime_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign pix_if.out_valid = out_valid_q;
    assign pix_if.out_pixel = out_pixel_q;
    assign pix_if.out_addr  = out_addr_q;
endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter on an 8x6 image: a frame-level Sobel model feeds a
// scoreboard queue, and a scenario table checks output counts against hand-derived values.
module tb_sobel_filter;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int PIX_W  = 4;
    localparam int ADDR_W = 6;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PRIME  = IMG_W + 1;
    localparam int THR    = 8;
`ifdef SOBEL_THRESHOLD_EN
    localparam int NZ_V1  = 0;
`else
    localparam int NZ_V1  = 12;
`endif

    typedef struct {
        int pattern;
        int gap;
        int frames;
        int exp_outs;
        int exp_nz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sobel_filter_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) pix_if ();

    sobel_filter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix_if(pix_if)
    );

    logic [ADDR_W+PIX_W-1:0] exp_q[$];
    int stream [1024];
    int acc_cnt;
    int n_checks;
    int n_pass;
    int outs_seen;
    int nz_seen;
    logic exp_v;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int px(int k, int dr, int dc);
        return stream[k + dr * IMG_W + dc];
    endfunction

    function automatic logic [PIX_W-1:0] golden(int k);
        int r, c, gx, gy, mag;
        r = (k / IMG_W) % IMG_H;
        c = k % IMG_W;
        if (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1) return '0;
        gx = (px(k, -1, 1) + 2 * px(k, 0, 1) + px(k, 1, 1))
           - (px(k, -1, -1) + 2 * px(k, 0, -1) + px(k, 1, -1));
        gy = (px(k, 1, -1) + 2 * px(k, 1, 0) + px(k, 1, 1))
           - (px(k, -1, -1) + 2 * px(k, -1, 0) + px(k, -1, 1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 15) mag = 15;
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= THR) ? 4'hF : 4'h0;
`else
        return PIX_W'(mag);
`endif
    endfunction

    function automatic logic [PIX_W-1:0] pat_pix(int pattern, int r, int c);
        case (pattern)
            0:       return 4'd5;
            1:       return (c >= 4) ? 4'd15 : 4'd0;
            2:       return (r >= 3) ? 4'd1 : 4'd0;
            3:       return (r >= 3) ? 4'd15 : 4'd0;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // One clock: drive, let the edge happen, update the model, then sample 1 time unit later.
    task automatic step(input logic fs, input logic v, input logic [PIX_W-1:0] pix);
        logic [ADDR_W+PIX_W-1:0] e;
        int k;
        pix_if.frame_start = fs;
        pix_if.in_valid    = v;
        pix_if.in_pixel    = pix;
        @(posedge clk);
        if (fs) acc_cnt = 0;
        exp_v = 1'b0;
        if (v) begin
            stream[acc_cnt] = pix;
            if (acc_cnt >= PRIME) begin
                k = acc_cnt - PRIME;
                exp_q.push_back({ADDR_W'(k % NPIX), golden(k)});
                exp_v = 1'b1;
            end
            acc_cnt++;
        end
        #1;
        pix_if.frame_start = 1'b0;
        pix_if.in_valid    = 1'b0;
        check("out_valid", 32'(pix_if.out_valid), 32'(exp_v));
        if (pix_if.out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got addr %0d with empty scoreboard", pix_if.out_addr);
            end else begin
                e = exp_q.pop_front();
                check("out_addr", 32'(pix_if.out_addr), 32'(e[ADDR_W+PIX_W-1:PIX_W]));
                check("out_pixel", 32'(pix_if.out_pixel), 32'(e[PIX_W-1:0]));
                outs_seen++;
                if (pix_if.out_pixel != 0) nz_seen++;
            end
        end
    endtask

    initial begin
        int silent;
        n_checks = 0;
        n_pass   = 0;
        acc_cnt  = 0;
        vecs[0] = '{pattern: 0, gap: 0, frames: 1, exp_outs: 39, exp_nz: 0};
        vecs[1] = '{pattern: 1, gap: 0, frames: 1, exp_outs: 39, exp_nz: 8};
        vecs[2] = '{pattern: 1, gap: 1, frames: 1, exp_outs: 39, exp_nz: 8};
        vecs[3] = '{pattern: 1, gap: 0, frames: 2, exp_outs: 87, exp_nz: 16};
        vecs[4] = '{pattern: 2, gap: 0, frames: 1, exp_outs: 39, exp_nz: NZ_V1};
        vecs[5] = '{pattern: 3, gap: 0, frames: 1, exp_outs: 39, exp_nz: 12};

        rst_n              = 1'b0;
        pix_if.frame_start = 1'b0;
        pix_if.in_valid    = 1'b0;
        pix_if.in_pixel    = '0;
        pix_if.threshold   = 4'(THR);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(pix_if.out_valid), 0);
        check("rst_out_pixel", 32'(pix_if.out_pixel), 0);
        check("rst_out_addr", 32'(pix_if.out_addr), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            outs_seen = 0;
            nz_seen   = 0;
            for (int f = 0; f < vecs[t].frames; f++) begin
                for (int i = 0; i < NPIX; i++) begin
                    if (vecs[t].gap != 0 && i > 0) step(1'b0, 1'b0, '0);
                    step(f == 0 && i == 0, 1'b1, pat_pix(vecs[t].pattern, i / IMG_W, i % IMG_W));
                end
            end
            check($sformatf("vec%0d_outputs", t), 32'(outs_seen), 32'(vecs[t].exp_outs));
            check($sformatf("vec%0d_nonzero", t), 32'(nz_seen), 32'(vecs[t].exp_nz));
        end

        // Interrupt a frame after 20 pixels: nothing pending may come out, priming restarts.
        for (int i = 0; i < 20; i++) step(i == 0, 1'b1, pat_pix(1, i / IMG_W, i % IMG_W));
        silent = 0;
        for (int i = 0; i < PRIME; i++) begin
            step(i == 0, 1'b1, pat_pix(1, i / IMG_W, i % IMG_W));
            if (pix_if.out_valid) silent++;
        end
        check("restart_silent", 32'(silent), 0);
        step(1'b0, 1'b1, pat_pix(1, 1, 1));
        check("restart_first_valid", 32'(pix_if.out_valid), 1);
        check("restart_first_addr", 32'(pix_if.out_addr), 0);

        // Reset in the middle of a frame right after a saturated result.
        for (int i = 0; i < 30; i++) step(i == 0, 1'b1, pat_pix(1, i / IMG_W, i % IMG_W));
        check("pre_reset_pixel", 32'(pix_if.out_pixel), 15);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(pix_if.out_valid), 0);
        check("midrst_out_pixel", 32'(pix_if.out_pixel), 0);
        check("midrst_out_addr", 32'(pix_if.out_addr), 0);
        exp_q.delete();
        acc_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // First frame after reset needs no frame_start.
        outs_seen = 0;
        for (int i = 0; i < NPIX; i++) step(1'b0, 1'b1, pat_pix(9, 0, 0));
        check("post_reset_outputs", 32'(outs_seen), 39);

        // Random pixels with random idle gaps.
        for (int i = 0; i < NPIX; i++) begin
            if (i > 0 && $urandom_range(0, 2) == 0) step(1'b0, 1'b0, '0);
            step(i == 0, 1'b1, pat_pix(9, 0, 0));
        end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
